// File: rtl/ahb_master.sv
// ahb_master: single-transfer AHB master. Turns one-cycle local write/read
// request pulses into NONSEQ SINGLE word transfers, one outstanding at a time.
// Ports:
//   HCLK, HRESETn                  clock, async active-low reset
//   HREADY, HRESP, HRDATA          slave response
//   request_write/request_read     one-cycle local request pulses
//   write_addr/write_data/read_addr request payload, sampled with the pulse
//   HADDR, HWDATA, HWRITE, HTRANS  AHB transfer signals (registered)
//   HSIZE, HBURST, HPROT           fixed word / SINGLE / privileged data
//   read_data, xfer_done, xfer_error  local completion status (registered)
module ahb_master (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HREADY,
   input  logic [1:0]  HRESP,
   input  logic [31:0] HRDATA,
   input  logic        request_write,
   input  logic        request_read,
   input  logic [31:0] write_data,
   input  logic [31:0] read_addr,
   input  logic [31:0] write_addr,
   output logic [31:0] HADDR,
   output logic [31:0] HWDATA,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic [1:0]  HTRANS,
   output logic [31:0] read_data,
   output logic        xfer_done,
   output logic        xfer_error
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam logic [1:0] RESP_ERROR   = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [ADDR_W-1:0]   r_haddr, w_haddr_nxt;
   logic [DATA_W-1:0]   r_hwdata, w_hwdata_nxt;
   logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
   logic                r_hwrite, w_hwrite_nxt;
   logic [1:0]          r_htrans, w_htrans_nxt;
   logic [DATA_W-1:0]   r_read_data, w_read_data_nxt;
   logic                r_done, w_done_nxt;
   logic                r_error, w_error_nxt;

   // State and all bus/local outputs are registered together.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state     <= ST_IDLE;
         r_haddr     <= '0;
         r_hwdata    <= '0;
         r_wdata     <= '0;
         r_hwrite    <= 1'b0;
         r_htrans    <= TRANS_IDLE;
         r_read_data <= '0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_haddr     <= w_haddr_nxt;
         r_hwdata    <= w_hwdata_nxt;
         r_wdata     <= w_wdata_nxt;
         r_hwrite    <= w_hwrite_nxt;
         r_htrans    <= w_htrans_nxt;
         r_read_data <= w_read_data_nxt;
         r_done      <= w_done_nxt;
         r_error     <= w_error_nxt;
      end
   end

   // Next-state and next-output logic; everything holds unless changed below.
   always_comb begin
      w_state_nxt     = r_state;
      w_haddr_nxt     = r_haddr;
      w_hwdata_nxt    = r_hwdata;
      w_wdata_nxt     = r_wdata;
      w_hwrite_nxt    = r_hwrite;
      w_htrans_nxt    = r_htrans;
      w_read_data_nxt = r_read_data;
      w_done_nxt      = 1'b0;
      w_error_nxt     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // Write has priority; a simultaneous read is dropped.
            if (request_write) begin
               w_haddr_nxt  = write_addr;
               w_wdata_nxt  = write_data;
               w_hwrite_nxt = 1'b1;
               w_htrans_nxt = TRANS_NONSEQ;
               w_state_nxt  = ST_ADDR;
            end else if (request_read) begin
               w_haddr_nxt  = read_addr;
               w_hwrite_nxt = 1'b0;
               w_htrans_nxt = TRANS_NONSEQ;
               w_state_nxt  = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (HREADY) begin
               w_htrans_nxt = TRANS_IDLE;
               if (r_hwrite) begin
                  w_hwdata_nxt = r_wdata;
               end
               w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (HREADY) begin
               if (HRESP == RESP_OKAY) begin
                  w_done_nxt = 1'b1;
                  if (!r_hwrite) begin
                     w_read_data_nxt = HRDATA;
                  end
                  w_state_nxt = ST_IDLE;
               end else if (HRESP == RESP_ERROR) begin
                  w_done_nxt  = 1'b1;
                  w_error_nxt = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  // RETRY/SPLIT: reissue the held address, direction and data.
                  w_htrans_nxt = TRANS_NONSEQ;
                  w_state_nxt  = ST_ADDR;
               end
            end
         end
         default: begin
            w_htrans_nxt = TRANS_IDLE;
            w_state_nxt  = ST_IDLE;
         end
      endcase
   end

   assign HADDR      = r_haddr;
   assign HWDATA     = r_hwdata;
   assign HWRITE     = r_hwrite;
   assign HTRANS     = r_htrans;
   assign HSIZE      = 3'b010;
   assign HBURST     = 3'b000;
   assign HPROT      = 4'b0011;
   assign read_data  = r_read_data;
   assign xfer_done  = r_done;
   assign xfer_error = r_error;

endmodule

// File: tb/tb_ahb_master.sv
// Bench for ahb_master: a reactive slave model answers bus transfers with
// configured wait states and responses; a scoreboard queue holds the expected
// completion of each accepted request and a monitor checks every xfer_done.
module tb_ahb_master;

   logic        HCLK, HRESETn, HREADY;
   logic [1:0]  HRESP;
   logic [31:0] HRDATA;
   logic        request_write, request_read;
   logic [31:0] write_data, read_addr, write_addr;
   logic [31:0] HADDR, HWDATA;
   logic        HWRITE;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   logic [31:0] read_data;
   logic        xfer_done, xfer_error;

   ahb_master dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HREADY(HREADY), .HRESP(HRESP),
      .HRDATA(HRDATA), .request_write(request_write), .request_read(request_read),
      .write_data(write_data), .read_addr(read_addr), .write_addr(write_addr),
      .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .read_data(read_data),
      .xfer_done(xfer_done), .xfer_error(xfer_error)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] rdata;
      bit          err;
      int          retries;
      int          lat;
      int          req_cyc;
   } exp_t;

   exp_t exp_q[$];
   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   int done_cnt = 0;
   bit prev_done = 0;

   // Current transfer as the slave model should see it.
   bit          cur_wr;
   logic [31:0] cur_addr, cur_wdata, cur_rdata;
   bit          cur_err;
   int          cur_wa, cur_wd;
   int          s_retries_left = 0;
   int          s_attempts = 0;
   int          s_acnt = 0, s_dcnt = 0;
   bit          s_in_data = 0;
   logic [31:0] model_rd = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
   endtask

   always @(posedge HCLK) cyc++;

   // Slave model: decides HREADY/HRESP for the next rising edge.
   always @(negedge HCLK) begin
      if (!HRESETn) begin
         s_in_data = 0; s_acnt = 0; s_dcnt = 0;
         HREADY = 1'b1; HRESP = 2'b00; HRDATA = $urandom;
      end else if (s_in_data) begin
         chk("htrans_data_phase", 32'(HTRANS), 32'h0);
         if (cur_wr) chk("hwdata", HWDATA, cur_wdata);
         if (s_dcnt >= cur_wd) begin
            HREADY = 1'b1;
            HRDATA = cur_rdata;
            if (s_retries_left > 0) begin
               HRESP = 2'b10;
               s_retries_left--;
            end else begin
               HRESP = cur_err ? 2'b01 : 2'b00;
            end
            s_in_data = 0; s_dcnt = 0;
         end else begin
            HREADY = 1'b0; HRESP = 2'b00; HRDATA = $urandom;
            s_dcnt++;
         end
      end else if (HTRANS == 2'b10) begin
         if (s_acnt == 0) begin
            s_attempts++;
            chk("haddr_nonseq", HADDR, cur_addr);
            chk("hwrite_nonseq", 32'(HWRITE), 32'(cur_wr));
         end
         HRESP = 2'b00; HRDATA = $urandom;
         if (s_acnt >= cur_wa) begin
            HREADY = 1'b1; s_in_data = 1; s_acnt = 0;
         end else begin
            HREADY = 1'b0; s_acnt++;
         end
      end else begin
         HREADY = 1'b1; HRESP = 2'b00; HRDATA = $urandom;
      end
   end

   // Monitor: every completion is matched against the scoreboard head.
   always @(negedge HCLK) begin
      if (HRESETn && xfer_done) begin
         chk("done_one_cycle", 32'(prev_done), 32'h0);
         if (exp_q.size() == 0) begin
            chk("done_unexpected", 32'h1, 32'h0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("xfer_error", 32'(xfer_error), 32'(e.err));
            chk("read_data", read_data, e.rdata);
            chk("haddr_done", HADDR, e.addr);
            chk("hwrite_done", 32'(HWRITE), 32'(e.wr));
            chk("htrans_done", 32'(HTRANS), 32'h0);
            chk("attempts", 32'(s_attempts), 32'(e.retries + 1));
            chk("latency", 32'(cyc - e.req_cyc), 32'(e.lat));
         end
         done_cnt++;
      end
      prev_done = HRESETn ? xfer_done : 1'b0;
   end

   task automatic tick();
      @(negedge HCLK);
      #1;
   endtask

   // kind: 0 write, 1 read, 2 both (write must win).
   task automatic issue(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int wa, input int wd,
                        input int retries, input bit err, input bit junk);
      exp_t e;
      cur_wr = (kind != 1);
      cur_addr = addr; cur_wdata = wdata; cur_rdata = rdata; cur_err = err;
      cur_wa = wa; cur_wd = wd; s_retries_left = retries; s_attempts = 0;
      e.wr = cur_wr; e.addr = addr; e.err = err; e.retries = retries;
      e.lat = (retries + 1) * (2 + wa + wd);
      e.req_cyc = cyc + 1;
      if (!cur_wr && !err) model_rd = rdata;
      e.rdata = model_rd;
      exp_q.push_back(e);
      if (kind == 1) begin
         read_addr = addr; request_read = 1'b1;
         write_addr = $urandom; write_data = $urandom;
      end else begin
         write_addr = addr; write_data = wdata; request_write = 1'b1;
         read_addr = (kind == 2) ? ~addr : $urandom;
         request_read = (kind == 2);
      end
      tick();
      request_write = 1'b0; request_read = 1'b0;
      // A request while busy must be ignored.
      if (junk) begin
         write_addr = $urandom; write_data = $urandom; read_addr = $urandom;
         request_write = $urandom_range(0, 1) == 1;
         request_read = 1'b1;
      end
      tick();
      request_write = 1'b0; request_read = 1'b0;
   endtask

   task automatic wait_done(input int start);
      int n = 0;
      while (done_cnt == start && n < 300) begin
         tick();
         n++;
      end
      if (done_cnt == start) begin
         chk("done_timeout", 32'h0, 32'h1);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
   endtask

   task automatic txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int wa, input int wd,
                      input int retries, input bit err, input bit junk);
      int start = done_cnt;
      issue(kind, addr, wdata, rdata, wa, wd, retries, err, junk);
      wait_done(start);
   endtask

   task automatic chk_reset_vals();
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hwdata", HWDATA, 32'h0);
      chk("rst_hwrite", 32'(HWRITE), 32'h0);
      chk("rst_htrans", 32'(HTRANS), 32'h0);
      chk("rst_hsize", 32'(HSIZE), 32'h2);
      chk("rst_hburst", 32'(HBURST), 32'h0);
      chk("rst_hprot", 32'(HPROT), 32'h3);
      chk("rst_read_data", read_data, 32'h0);
      chk("rst_xfer_done", 32'(xfer_done), 32'h0);
      chk("rst_xfer_error", 32'(xfer_error), 32'h0);
   endtask

   initial begin
      HRESETn = 1'b0; HREADY = 1'b1; HRESP = 2'b00; HRDATA = 32'h0;
      request_write = 1'b0; request_read = 1'b0;
      write_data = 32'h0; read_addr = 32'h0; write_addr = 32'h0;
      cur_wr = 0; cur_addr = 0; cur_wdata = 0; cur_rdata = 0; cur_err = 0;
      cur_wa = 0; cur_wd = 0;
      tick();
      chk_reset_vals();
      // A request during reset must not be latched.
      write_addr = 32'h1234_5678; write_data = 32'h1; request_write = 1'b1;
      tick();
      chk_reset_vals();
      request_write = 1'b0;
      HRESETn = 1'b1;
      tick();
      chk("htrans_after_reset", 32'(HTRANS), 32'h0);

      txn(0, 32'h4000_0000, 32'hA5A5_A5A5, 32'h0, 0, 0, 0, 0, 0);
      txn(1, 32'h4000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
      txn(0, 32'h4000_0008, 32'h1357_9BDF, 32'h0, 0, 2, 0, 0, 0);
      txn(1, 32'h4000_000C, 32'h0, 32'h0BAD_0BAD, 0, 0, 0, 1, 0);
      chk("read_data_kept", read_data, 32'hDEAD_BEEF);
      txn(0, 32'h4000_0010, 32'hCAFE_F00D, 32'h0, 0, 0, 1, 0, 0);
      txn(2, 32'h4000_0014, 32'h2468_ACE0, 32'h0, 0, 0, 0, 0, 0);
      txn(1, 32'h4000_0018, 32'h0, 32'h7777_1111, 1, 1, 1, 0, 1);

      for (int i = 0; i < 60; i++) begin
         int kind = $urandom_range(0, 2);
         logic [31:0] a = $urandom & 32'hFFFF_FFFC;
         logic [31:0] wdat = $urandom;
         logic [31:0] rdat = $urandom;
         int wa = $urandom_range(0, 2);
         int wd = $urandom_range(0, 3);
         int rt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
         bit er = $urandom_range(0, 4) == 0;
         bit jk = $urandom_range(0, 1) == 1;
         txn(kind, a, wdat, rdat, wa, wd, rt, er, jk);
      end

      // Reset mid data phase: immediate reset values, transfer not reported.
      issue(0, 32'h4000_0100, 32'h5A5A_5A5A, 32'h0, 0, 6, 0, 0, 0);
      chk("hwdata_pre_reset", HWDATA, 32'h5A5A_5A5A);
      HRESETn = 1'b0;
      #1;
      chk_reset_vals();
      exp_q.delete();
      model_rd = 32'h0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("no_done_in_reset", 32'(xfer_done), 32'h0);
      end
      HRESETn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("no_done_after_reset", 32'(xfer_done), 32'h0);
         chk("idle_after_reset", 32'(HTRANS), 32'h0);
      end
      txn(1, 32'h4000_0200, 32'h0, 32'h0F0F_F0F0, 0, 1, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ahb_master.md
# ahb_master

Single-transfer AHB bus master converting one-cycle local write/read request pulses into AHB NONSEQ SINGLE word transfers. Sits between a local controller and the AHB interconnect/slave. One transfer outstanding at a time, with no queueing. Returns read data and a completion/error strobe to the local side.

## Interface
Parameters: none. HSIZE, HBURST and HPROT are fixed constants.

Ports (one clock; reset is asynchronous and active-low):
- HCLK  in  1  bus clock; all state updates on rising edge
- HRESETn  in  1  asynchronous active-low reset
- HREADY  in  1  slave ready; high completes the current phase
- HRESP  in  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT
- HRDATA  in  32  read data from slave
- request_write  in  1  one-cycle pulse to start a write
- request_read  in  1  one-cycle pulse to start a read
- write_data  in  32  write payload, sampled with the request
- read_addr  in  32  read address, sampled with request_read
- write_addr  in  32  write address, sampled with request_write
- HADDR  out  32  transfer address
- HWDATA  out  32  write data, driven in data phase
- HWRITE  out  1  1 write, 0 read
- HSIZE  out  3  constant 3'b010 (word)
- HBURST  out  3  constant 3'b000 (SINGLE)
- HPROT  out  4  constant 4'b0011 (non-cacheable, non-bufferable, privileged, data)
- HTRANS  out  2  00 IDLE, 10 NONSEQ
- read_data  out  32  captured HRDATA of the last read
- xfer_done  out  1  one-cycle pulse when a transfer completes
- xfer_error  out  1  valid with xfer_done; 1 if completed with ERROR

## Operation
- FSM states:
  - IDLE: HTRANS=00; requests accepted only here.
  - ADDR: HTRANS=10; HADDR/HWRITE valid.
  - DATA: HTRANS=00; HWDATA valid for writes.
- IDLE transitions:
  - request_write sampled high: latch write_addr and write_data, set HWRITE=1, go to ADDR.
  - Else request_read sampled high: latch read_addr, set HWRITE=0, go to ADDR.
  - Both high: the write wins and the read is dropped.
- ADDR transitions:
  - HREADY=1: go to DATA and drive HWDATA with the latched data on writes.
  - HREADY=0: hold all address-phase signals.
- DATA transitions:
  - HREADY=0: stay, holding HWDATA.
  - HREADY=1 with HRESP=OKAY: complete. On a read, capture HRDATA into read_data. Pulse xfer_done with xfer_error=0, then go to IDLE.
  - HREADY=1 with HRESP=ERROR: complete with xfer_done=1 and xfer_error=1. read_data is unchanged. Go to IDLE.
  - HREADY=1 with HRESP=RETRY or SPLIT: no completion. Return to ADDR and reissue the same transfer with the same address, direction and data.
- Requests arriving outside IDLE are ignored and not queued.
- Registered outputs, all with the values below on HRESETn low, applied immediately even mid-transfer:
  - HADDR=0, HWDATA=0, HWRITE=0, HTRANS=00
  - HSIZE=010, HBURST=000, HPROT=0011
  - read_data=0, xfer_done=0, xfer_error=0
  - State returns to IDLE; any in-flight transfer is abandoned and not reported.
- HADDR, HWRITE and HWDATA hold their last values while in IDLE.

## Timing
- Request sampled at edge N. From N, HTRANS=NONSEQ and HADDR/HWRITE are valid.
- Zero wait states:
  - Address phase completes at N+1; HWDATA is valid from N+1 and HTRANS returns to IDLE.
  - Data phase completes at N+2; read_data updates and xfer_done goes high from N+2 for exactly one cycle.
  - Earliest next accepted request: edge N+3. Back-to-back throughput is one transfer per 3 cycles.
- Each HREADY=0 cycle in either phase adds one cycle.
- RETRY or SPLIT at edge M: NONSEQ is driven again from M.
- A request pulse of exactly one HCLK period must be caught. No request is latched while HRESETn is low.

## Test plan
- Reset low 20 ns, HREADY=1: all outputs equal their reset values; HTRANS=00 throughout.
- Write pulse with write_addr=0x4000_0000 and write_data=0xA5A5A5A5:
  - Next cycle: HTRANS=10, HADDR=0x4000_0000, HWRITE=1.
  - Following cycle: HWDATA=0xA5A5A5A5, HTRANS=00.
  - xfer_done=1 and xfer_error=0 one cycle later.
- Read pulse with read_addr=0x4000_0004 and HRDATA=0xDEADBEEF: HTRANS=10 with HADDR=0x4000_0004 and HWRITE=0. At data-phase completion read_data=0xDEADBEEF and xfer_done pulses.
- Write with HREADY low for 2 data-phase cycles: HWDATA is held, and xfer_done is delayed by exactly 2 cycles.
- Read answered with HRESP=01: xfer_error=1 with xfer_done, read_data is unchanged, and the FSM returns to IDLE.
- RETRY, then simultaneous requests, then reset:
  - HRESP=10 on a write: NONSEQ is reissued to the same address.
  - request_write and request_read together: only the write is performed.
  - HRESETn dropped in DATA: outputs go to reset values immediately and no xfer_done is produced.
